// File: rtl/jk_flip_flop.sv
`default_nettype none
// ============================================================================
// Module      : jk_flip_flop
// Description : WIDTH independent edge-triggered JK cells sharing clock,
//               async active-low clear (dominant) and async active-low preset.
// Revision    : 1.0 - initial release
// ============================================================================
module jk_flip_flop #(
  parameter int WIDTH  = 1,
  parameter bit INIT_Q = 1'b0
) (
  input  logic             CLK,
  input  logic             ClrN,
  input  logic             SetN,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN
);

  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic             w_set_act_n;

  generate
    if (INIT_Q != 1'b0) begin : g_init_q_check
      $error("jk_flip_flop: INIT_Q is reserved and must be 0");
    end
  endgenerate

  // Preset is only effective while clear is released, so releasing clear with
  // preset still low produces a falling edge here and loads all ones at once.
  assign w_set_act_n = SetN | ~ClrN;

  always_comb begin
    state_d = state_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({J[i], K[i]})
        2'b01:   state_d[i] = 1'b0;
        2'b10:   state_d[i] = 1'b1;
        2'b11:   state_d[i] = ~state_q[i];
        default: state_d[i] = state_q[i];
      endcase
    end
  end

  always_ff @(posedge CLK or negedge ClrN or negedge w_set_act_n) begin
    if (!ClrN) begin
      state_q <= '0;
    end else if (!w_set_act_n) begin
      state_q <= '1;
    end else begin
      state_q <= state_d;
    end
  end

  assign Q  = state_q;
  assign QN = ~state_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_flip_flop.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_flip_flop
// Description : Directed self-checking bench for 1-bit and 4-bit JK cells.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_flip_flop;

  logic       CLK = 1'b0;
  logic       ClrN, SetN, J, K;
  logic       Q, QN;
  logic       ClrN2, SetN2;
  logic [3:0] J2, K2, Q2, QN2;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  jk_flip_flop #(.WIDTH(1), .INIT_Q(1'b0)) u_dut1 (
    .CLK (CLK), .ClrN(ClrN), .SetN(SetN), .J(J), .K(K), .Q(Q), .QN(QN)
  );

  jk_flip_flop #(.WIDTH(4), .INIT_Q(1'b0)) u_dut4 (
    .CLK (CLK), .ClrN(ClrN2), .SetN(SetN2), .J(J2), .K(K2), .Q(Q2), .QN(QN2)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic exp_q);
    chk({tag, ".q"},  {3'b000, Q},  {3'b000, exp_q});
    chk({tag, ".qn"}, {3'b000, QN}, {3'b000, ~exp_q});
  endtask

  task automatic chk4(input string tag, input logic [3:0] exp_q);
    chk({tag, ".q"},  Q2,  exp_q);
    chk({tag, ".qn"}, QN2, ~exp_q);
  endtask

  initial begin
    ClrN = 1'b0; SetN = 1'b0; J = 1'b0; K = 1'b0;
    ClrN2 = 1'b0; SetN2 = 1'b0; J2 = 4'b0000; K2 = 4'b0000;
    #1;
    chk1("reset_both_low", 1'b0);
    chk4("reset_both_low_w4", 4'b0000);

    // Clear dominates preset across several edges
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk1("clr_dominates", 1'b0);
    end

    // Preset released while clear held, then clear released with preset low
    SetN = 1'b1;
    @(negedge CLK);
    chk1("clr_low_set_high", 1'b0);
    SetN = 1'b0;
    #1;
    chk1("clr_low_set_low_again", 1'b0);
    ClrN = 1'b1;
    #1;
    chk1("set_after_clr_release", 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk1("set_held", 1'b1);
    end

    // Clear to 0, release both between edges: state stays until next edge
    ClrN = 1'b0;
    #1;
    chk1("clr_over_set", 1'b0);
    SetN = 1'b1;
    #1;
    ClrN = 1'b1;
    #1;
    chk1("release_no_edge", 1'b0);

    // J=1 K=0 sets, then hold
    J = 1'b1; K = 1'b0;
    @(negedge CLK);
    chk1("jk_set", 1'b1);
    J = 1'b0; K = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk1("jk_hold", 1'b1);
    end

    // J=0 K=1 resets
    K = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk1("jk_reset", 1'b0);
    end

    // Toggle 1,0,1,0; no change on falling edges or on mid-cycle J/K wiggles
    J = 1'b1; K = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      chk1("toggle_rise", (i % 2 == 0) ? 1'b1 : 1'b0);
      J = 1'b0; K = 1'b1;
      #2;
      chk1("toggle_jk_wiggle", (i % 2 == 0) ? 1'b1 : 1'b0);
      J = 1'b1; K = 1'b1;
      @(negedge CLK);
      #1;
      chk1("toggle_fall", (i % 2 == 0) ? 1'b1 : 1'b0);
    end

    // Mid-toggle clear pulse of 3 ns
    @(posedge CLK);
    #1;
    chk1("toggle_before_pulse", 1'b1);
    #2;
    ClrN = 1'b0;
    #1;
    chk1("clr_pulse_immediate", 1'b0);
    #2;
    ClrN = 1'b1;
    #1;
    chk1("clr_pulse_released", 1'b0);
    @(posedge CLK);
    #1;
    chk1("toggle_resume", 1'b1);

    // Clear held across an edge: the edge is ignored
    #2;
    ClrN = 1'b0;
    @(posedge CLK);
    #1;
    chk1("edge_during_clr", 1'b0);
    ClrN = 1'b1;

    // Mid-cycle preset assertion, edge during preset ignored
    #2;
    J = 1'b0; K = 1'b1;
    SetN = 1'b0;
    #1;
    chk1("preset_immediate", 1'b1);
    @(posedge CLK);
    #1;
    chk1("edge_during_set", 1'b1);
    SetN = 1'b1;
    @(posedge CLK);
    #1;
    chk1("after_set_release_k", 1'b0);

    // 4-bit instance: preset, then load 0011, then mixed JK
    ClrN2 = 1'b1;
    #1;
    chk4("w4_preset", 4'b1111);
    SetN2 = 1'b1;
    ClrN2 = 1'b0;
    #1;
    chk4("w4_clear", 4'b0000);
    ClrN2 = 1'b1;
    J2 = 4'b0011; K2 = 4'b1100;
    @(posedge CLK);
    #1;
    chk4("w4_load_0011", 4'b0011);
    J2 = 4'b1010; K2 = 4'b0110;
    @(posedge CLK);
    #1;
    chk4("w4_mixed", 4'b1001);
    J2 = 4'b0000; K2 = 4'b0000;
    @(posedge CLK);
    #1;
    chk4("w4_hold", 4'b1001);
    J2 = 4'b1111; K2 = 4'b1111;
    @(posedge CLK);
    #1;
    chk4("w4_toggle", 4'b0110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
